pio_bus_master: RTL and testbench
=================================

Name: pio_bus_master

Overview:
- Bus initiator for the 8-bit CPU-style peripheral bus (addr / data_tx / data_rx / cs_n / oe_n / we_n) used by the PIO and sibling peripherals.
- Converts single-word valid/ready requests from an internal sequencer into fully timed read or write bus cycles with programmable setup, strobe and hold phases.
- Returns a one-cycle response pulse carrying read data.
- Sits between a command source (UART bridge or soft sequencer) and one or more bus responders.

Parameters:
- ADDR_W, 2, bus address width
- DATA_W, 8, bus data width
- SETUP_CYC, 1, cycles address/data are stable before strobe (1..15)
- STROBE_CYC, 2, cycles cs_n plus oe_n or we_n are held low (1..15)
- HOLD_CYC, 1, cycles address/data are held after strobe release (1..15)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  target address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_write  out  1  type of the completed transaction
- rsp_rdata  out  DATA_W  read data of the last completed read
- busy  out  1  transaction in progress
- addr  out  ADDR_W  bus address
- data_tx  out  DATA_W  bus write data
- data_rx  in  DATA_W  bus read data
- cs_n  out  1  chip select, active low
- oe_n  out  1  output enable (read strobe), active low
- we_n  out  1  write enable, active low

Behaviour:
- Reset: reset is synchronous, active-low; clock is clk. While reset is low, on every clk edge:
  - state = IDLE
  - cs_n = oe_n = we_n = 1
  - addr = 0, data_tx = 0
  - rsp_valid = 0, rsp_write = 0, rsp_rdata = 0
  - busy = 0; req_ready = 0 (gated by reset)
- Output timing: all bus outputs are registered, with no combinational path from req_* to bus pins. req_ready = (state == IDLE) && reset.
- Request acceptance: handshake on a clk edge with req_valid && req_ready. At that edge, latch req_write, req_addr and req_wdata. data_tx = req_wdata for writes, 0 for reads. Enter SETUP, load the phase counter with SETUP_CYC, and set busy = 1.
- States:
  - IDLE: strobes high. addr and data_tx hold their last values. Stay until handshake.
  - SETUP: cs_n = oe_n = we_n = 1 and addr valid, for SETUP_CYC cycles. Then go to STROBE with the counter loaded with STROBE_CYC.
  - STROBE: cs_n = 0; oe_n = 0 if read, else we_n = 0; never both. Lasts STROBE_CYC cycles. For reads, data_rx is captured into an internal register at the edge that ends the last strobe cycle. Then go to HOLD.
  - HOLD: strobes high; addr and data_tx unchanged for HOLD_CYC cycles. Then go to RESP.
  - RESP: one cycle. rsp_valid = 1 and rsp_write = latched type. For a read, rsp_rdata = captured data; for a write, rsp_rdata is unchanged. busy = 1. Next state is IDLE.
- rsp_rdata holds its value until the next read completes.
- Latency: with handshake at edge 0, the bus phases occupy cycles 1..S, S+1..S+T and S+T+1..S+T+H. rsp_valid is high in cycle S+T+H+1. req_ready returns high in cycle S+T+H+2. With defaults: response in cycle 5, next accept earliest at the edge ending cycle 6.
- Back-to-back: a request held valid through the response is accepted on the first IDLE cycle. Strobes are therefore high for at least HOLD_CYC + 1 + 1 + SETUP_CYC cycles between consecutive transactions.
- Request inputs: ignored outside IDLE. Changes to req_* after the handshake do not affect the bus cycle in flight.
- Reset mid-transaction: strobes go high and state goes to IDLE at the next edge. No rsp_valid is generated for the aborted transaction. rsp_rdata is cleared.
- Parameter legality: SETUP_CYC, STROBE_CYC or HOLD_CYC outside 1..15 must cause an elaboration error. The counter is 4 bits.

Test Plan:
- Reset → release with defaults: cs_n = oe_n = we_n = 1, rsp_valid = 0, req_ready = 0 during reset and 1 in the first cycle after.
- Write addr 0, data 0x01 (defaults) → cycle 1: addr = 0, data_tx = 0x01, strobes high; cycles 2–3: cs_n = 0, we_n = 0, oe_n = 1; cycle 4: strobes high, data_tx = 0x01; cycle 5: rsp_valid = 1, rsp_write = 1. A PIO responder's config register reads back 0x01.
- Read addr 1 with data_rx = 0xA5 during strobe, changing to 0x00 after → cycles 2–3: cs_n = 0, oe_n = 0; cycle 5: rsp_valid = 1, rsp_write = 0, rsp_rdata = 0xA5; rsp_rdata stays 0xA5 through a following write.
- SETUP_CYC = 3, STROBE_CYC = 4, HOLD_CYC = 2, read → strobe low exactly in cycles 4–7, rsp_valid in cycle 10 only. req_ready = 0 from cycle 1 through 10.
- req_valid held high with two queued writes (0x11, 0x22) → two complete bus cycles; 6 cycles between handshakes with defaults; inputs changed mid-cycle do not alter data_tx.
- Reset asserted in the second strobe cycle of a write → next edge: cs_n = we_n = 1, state IDLE. No rsp_valid is produced. req_ready = 1 in the first cycle after reset release.

Source files
------------

// File: rtl/pio_bus_if.sv
// pio_bus_if: request/response handshake plus the 8-bit CPU-style peripheral
// bus, bundled for pio_bus_master.
//   req_valid/req_ready/req_write/req_addr/req_wdata : request channel
//   rsp_valid/rsp_write/rsp_rdata                    : completion channel
//   busy                                             : transaction in progress
//   addr/data_tx/data_rx/cs_n/oe_n/we_n              : peripheral bus pins
// Modport master is the bus initiator's view; slave is the opposite side
// (command source plus bus responder).
interface pio_bus_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_tx;
    logic [DATA_W-1:0] data_rx;
    logic              cs_n;
    logic              oe_n;
    logic              we_n;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, data_rx,
        output req_ready, rsp_valid, rsp_write, rsp_rdata, busy,
        output addr, data_tx, cs_n, oe_n, we_n
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, data_rx,
        input  req_ready, rsp_valid, rsp_write, rsp_rdata, busy,
        input  addr, data_tx, cs_n, oe_n, we_n
    );
endinterface

// File: rtl/pio_bus_master.sv
// pio_bus_master: turns single-word valid/ready requests into timed read or
// write cycles on the peripheral bus (setup, strobe, hold), then emits a
// one-cycle response pulse carrying read data.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-low reset
//   bus   : pio_bus_if.master (request, response and bus pins)
// All bus pins are registered; req_ready depends only on state and reset.
module pio_bus_master #(
    parameter int ADDR_W     = 2,
    parameter int DATA_W     = 8,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input logic       clk,
    input logic       reset,
    pio_bus_if.master bus
);

    // Phase lengths must fit the 4-bit phase counter and be non-zero.
    if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
        $error("pio_bus_master: SETUP_CYC must be 1..15");
    end
    if (STROBE_CYC < 1 || STROBE_CYC > 15) begin : g_bad_strobe
        $error("pio_bus_master: STROBE_CYC must be 1..15");
    end
    if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
        $error("pio_bus_master: HOLD_CYC must be 1..15");
    end

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RESP
    } state_t;

    state_t            state;
    logic [3:0]        cnt;    // cycles left in the current phase, incl. this one
    logic              wr_q;   // latched transaction type
    logic [DATA_W-1:0] rx_q;   // data_rx sampled at the end of the strobe

    assign bus.req_ready = (state == IDLE) && reset;

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            wr_q          <= 1'b0;
            rx_q          <= '0;
            bus.cs_n      <= 1'b1;
            bus.oe_n      <= 1'b1;
            bus.we_n      <= 1'b1;
            bus.addr      <= '0;
            bus.data_tx   <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_write <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // req_ready is implied here: IDLE with reset released.
                    if (bus.req_valid) begin
                        wr_q        <= bus.req_write;
                        bus.addr    <= bus.req_addr;
                        bus.data_tx <= bus.req_write ? bus.req_wdata : '0;
                        cnt         <= 4'(SETUP_CYC);
                        bus.busy    <= 1'b1;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == 4'd1) begin
                        cnt      <= 4'(STROBE_CYC);
                        bus.cs_n <= 1'b0;
                        bus.oe_n <= wr_q;
                        bus.we_n <= !wr_q;
                        state    <= STROBE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                STROBE: begin
                    if (cnt == 4'd1) begin
                        // Sample at the edge that ends the last strobe cycle,
                        // while the responder is still driving.
                        if (!wr_q) rx_q <= bus.data_rx;
                        cnt      <= 4'(HOLD_CYC);
                        bus.cs_n <= 1'b1;
                        bus.oe_n <= 1'b1;
                        bus.we_n <= 1'b1;
                        state    <= HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 4'd1) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_write <= wr_q;
                        if (!wr_q) bus.rsp_rdata <= rx_q;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    bus.rsp_valid <= 1'b0;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pio_bus_master.sv
// tb_pio_bus_master: directed bench for pio_bus_master. Instance u_dut_a uses
// default timing (1/2/1) with a small register-file responder; u_dut_b uses
// 3/4/2 with a fixed read value. Outputs are sampled 1 time unit after each
// rising edge, so "cycle N" means the cycle following edge N.
module tb_pio_bus_master;

    logic clk;
    logic reset;

    int checks = 0;
    int errors = 0;

    pio_bus_if #(.ADDR_W(2), .DATA_W(8)) bus_a ();
    pio_bus_if #(.ADDR_W(2), .DATA_W(8)) bus_b ();

    pio_bus_master u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    pio_bus_master #(
        .ADDR_W(2), .DATA_W(8), .SETUP_CYC(3), .STROBE_CYC(4), .HOLD_CYC(2)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder A: 4-byte register file written during the write strobe;
    // address 1 reads as 0xA5. The bus reads 0x00 outside a read strobe.
    logic [7:0] resp_regs [4];
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) resp_regs[i] <= 8'h00;
        end else if (!bus_a.cs_n && !bus_a.we_n) begin
            resp_regs[bus_a.addr] <= bus_a.data_tx;
        end
    end
    assign bus_a.data_rx = (!bus_a.cs_n && !bus_a.oe_n)
                         ? ((bus_a.addr == 2'd1) ? 8'hA5 : resp_regs[bus_a.addr])
                         : 8'h00;
    assign bus_b.data_rx = (!bus_b.cs_n && !bus_b.oe_n) ? 8'h3C : 8'h00;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request to DUT A for one edge; on return we are in cycle 1.
    task automatic start_a(input logic wr, input logic [1:0] ad, input logic [7:0] wd);
        bus_a.req_valid = 1'b1;
        bus_a.req_write = wr;
        bus_a.req_addr  = ad;
        bus_a.req_wdata = wd;
        tick();
        bus_a.req_valid = 1'b0;
    endtask

    task automatic wait_ready_a();
        for (int i = 0; i < 50 && !bus_a.req_ready; i++) tick();
        check("ready_timeout", bus_a.req_ready, 1);
    endtask

    task automatic strobes_a(input string tag, input logic cs, input logic oe,
                             input logic we);
        check({tag, "_cs_n"}, bus_a.cs_n, cs);
        check({tag, "_oe_n"}, bus_a.oe_n, oe);
        check({tag, "_we_n"}, bus_a.we_n, we);
    endtask

    initial begin
        reset = 1'b0;
        bus_a.req_valid = 1'b0; bus_a.req_write = 1'b0;
        bus_a.req_addr  = '0;   bus_a.req_wdata = '0;
        bus_b.req_valid = 1'b0; bus_b.req_write = 1'b0;
        bus_b.req_addr  = '0;   bus_b.req_wdata = '0;

        // ---------------- reset ----------------
        tick(); tick(); tick();
        strobes_a("rst", 1, 1, 1);
        check("rst_rsp_valid", bus_a.rsp_valid, 0);
        check("rst_req_ready", bus_a.req_ready, 0);
        check("rst_busy", bus_a.busy, 0);
        check("rst_addr", bus_a.addr, 0);
        check("rst_data_tx", bus_a.data_tx, 0);
        check("rst_rdata", bus_a.rsp_rdata, 0);
        reset = 1'b1;
        #1;
        check("rel_req_ready", bus_a.req_ready, 1);
        check("rel_req_ready_b", bus_b.req_ready, 1);

        // ---------------- write addr 0, 0x01 ----------------
        start_a(1'b1, 2'd0, 8'h01);
        check("wr_c1_addr", bus_a.addr, 0);
        check("wr_c1_data", bus_a.data_tx, 8'h01);
        check("wr_c1_busy", bus_a.busy, 1);
        check("wr_c1_ready", bus_a.req_ready, 0);
        strobes_a("wr_c1", 1, 1, 1);
        bus_a.req_wdata = 8'hFF;   // must not reach the bus
        tick(); strobes_a("wr_c2", 0, 1, 0);
        tick(); strobes_a("wr_c3", 0, 1, 0);
        check("wr_c3_data", bus_a.data_tx, 8'h01);
        tick(); strobes_a("wr_c4", 1, 1, 1);
        check("wr_c4_data", bus_a.data_tx, 8'h01);
        check("wr_c4_rsp", bus_a.rsp_valid, 0);
        tick();
        check("wr_c5_rsp_valid", bus_a.rsp_valid, 1);
        check("wr_c5_rsp_write", bus_a.rsp_write, 1);
        check("wr_c5_busy", bus_a.busy, 1);
        tick();
        check("wr_c6_rsp_valid", bus_a.rsp_valid, 0);
        check("wr_c6_ready", bus_a.req_ready, 1);
        check("wr_c6_busy", bus_a.busy, 0);
        check("wr_reg0", resp_regs[0], 8'h01);

        // ---------------- read addr 1 -> 0xA5 ----------------
        start_a(1'b0, 2'd1, 8'h77);
        check("rd_c1_addr", bus_a.addr, 1);
        check("rd_c1_data_tx", bus_a.data_tx, 0);
        tick(); strobes_a("rd_c2", 0, 0, 1);
        tick(); strobes_a("rd_c3", 0, 0, 1);
        tick(); strobes_a("rd_c4", 1, 1, 1);
        check("rd_c4_rx_idle", bus_a.data_rx, 0);
        tick();
        check("rd_c5_rsp_valid", bus_a.rsp_valid, 1);
        check("rd_c5_rsp_write", bus_a.rsp_write, 0);
        check("rd_c5_rdata", bus_a.rsp_rdata, 8'hA5);
        tick();

        // write that must leave rsp_rdata untouched
        start_a(1'b1, 2'd2, 8'h5A);
        tick(); tick(); tick(); tick();
        check("wr2_rsp_valid", bus_a.rsp_valid, 1);
        check("wr2_rsp_write", bus_a.rsp_write, 1);
        check("wr2_rdata_kept", bus_a.rsp_rdata, 8'hA5);
        tick();
        check("wr2_reg2", resp_regs[2], 8'h5A);

        // read back the register written first
        start_a(1'b0, 2'd0, 8'h00);
        tick(); tick(); tick(); tick();
        check("rb_rsp_valid", bus_a.rsp_valid, 1);
        check("rb_rdata", bus_a.rsp_rdata, 8'h01);
        tick();

        // ---------------- DUT B: 3/4/2 read ----------------
        bus_b.req_valid = 1'b1;
        bus_b.req_write = 1'b0;
        bus_b.req_addr  = 2'd2;
        tick();
        bus_b.req_valid = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            check($sformatf("b_c%0d_cs_n", c), bus_b.cs_n, (c >= 4 && c <= 7) ? 0 : 1);
            check($sformatf("b_c%0d_oe_n", c), bus_b.oe_n, (c >= 4 && c <= 7) ? 0 : 1);
            check($sformatf("b_c%0d_we_n", c), bus_b.we_n, 1);
            check($sformatf("b_c%0d_rsp", c), bus_b.rsp_valid, (c == 10) ? 1 : 0);
            check($sformatf("b_c%0d_ready", c), bus_b.req_ready, (c == 11) ? 1 : 0);
            if (c == 10) check("b_rdata", bus_b.rsp_rdata, 8'h3C);
            if (c < 11) tick();
        end

        // ---------------- back-to-back writes 0x11, 0x22 ----------------
        bus_a.req_valid = 1'b1;
        bus_a.req_write = 1'b1;
        bus_a.req_addr  = 2'd3;
        bus_a.req_wdata = 8'h11;
        tick();                      // cycle 1 of first transaction
        check("bb1_data", bus_a.data_tx, 8'h11);
        bus_a.req_wdata = 8'h22;     // next request queued, valid kept high
        tick(); check("bb1_c2_data", bus_a.data_tx, 8'h11);
        strobes_a("bb1_c2", 0, 1, 0);
        tick(); tick(); tick();
        check("bb1_c5_rsp", bus_a.rsp_valid, 1);
        check("bb1_c5_ready", bus_a.req_ready, 0);
        tick();
        check("bb1_c6_ready", bus_a.req_ready, 1);
        strobes_a("bb1_c6", 1, 1, 1);
        check("bb_reg3_first", resp_regs[3], 8'h11);
        tick();                      // handshake at the edge ending cycle 6
        bus_a.req_valid = 1'b0;
        check("bb2_c1_busy", bus_a.busy, 1);
        check("bb2_c1_ready", bus_a.req_ready, 0);
        check("bb2_c1_data", bus_a.data_tx, 8'h22);
        strobes_a("bb2_c1", 1, 1, 1);
        tick(); strobes_a("bb2_c2", 0, 1, 0);
        wait_ready_a();
        check("bb_reg3_second", resp_regs[3], 8'h22);

        // ---------------- reset in second strobe cycle ----------------
        start_a(1'b1, 2'd2, 8'h77);
        tick();                      // cycle 2, first strobe cycle
        tick();                      // cycle 3, second strobe cycle
        strobes_a("ab_c3", 0, 1, 0);
        reset = 1'b0;
        #1;
        check("ab_ready_gated", bus_a.req_ready, 0);
        tick();
        strobes_a("ab_rst", 1, 1, 1);
        check("ab_rsp_valid", bus_a.rsp_valid, 0);
        check("ab_busy", bus_a.busy, 0);
        check("ab_rdata_clr", bus_a.rsp_rdata, 0);
        reset = 1'b1;
        #1;
        check("ab_rel_ready", bus_a.req_ready, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("ab_no_rsp%0d", i), bus_a.rsp_valid, 0);
            check($sformatf("ab_idle_cs%0d", i), bus_a.cs_n, 1);
        end
        check("ab_ready_after", bus_a.req_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
